uart_tx_cfg: RTL



---
 rtl/uart_tx_cfg.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional odd/even parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add break_req and a line-break state.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 active,
  output logic                 out_data,
  output logic                 done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W  = $clog2(DATA_BITS) + 1;
  localparam bit PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam int FRAME_CLKS = (1 + DATA_BITS + int'(PAR_EN) + STOP_BITS) * CLKS_PER_BIT;

  if (CLKS_PER_BIT < 2) begin : g_err_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 3) begin : g_err_pm
    $error("uart_tx_cfg: PARITY_MODE must be 0..3");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_sb
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 out_q, active_q, done_q;
  logic                 bit_end;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_W = $clog2(FRAME_CLKS) + 1;
  logic [BRK_W-1:0] brk_q;
  assign data_ready = (state_q == IDLE) && !break_req;
`else
  assign data_ready = (state_q == IDLE);
`endif

  assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign out_data = out_q;
  assign active   = active_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      out_q    <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q inside {START, DATA, PARITY, STOP})
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_q  <= BREAK;
            out_q    <= 1'b0;
            active_q <= 1'b1;
            brk_q    <= '0;
          end else
`endif
          if (data_valid) begin
            // start bit goes out on the accepting edge
            shreg_q  <= in_data;
            par_q    <= (PARITY_MODE == 1) ? ~^in_data : ^in_data;
            state_q  <= START;
            out_q    <= 1'b0;
            active_q <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
          end
        end
        START: if (bit_end) begin
          state_q <= DATA;
          out_q   <= shreg_q[0];
        end
        DATA: if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_q <= '0;
            if (PAR_EN) begin
              state_q <= PARITY;
              out_q   <= par_q;
            end else begin
              state_q <= STOP;
              out_q   <= 1'b1;
            end
          end else begin
            idx_q   <= idx_q + 1'b1;
            shreg_q <= shreg_q >> 1;
            out_q   <= shreg_q[1];
          end
        end
        PARITY: if (bit_end) begin
          state_q <= STOP;
          out_q   <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            idx_q    <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        // hold low at least one frame length, longer while break_req stays high
        BREAK: begin
          if (brk_q == BRK_W'(FRAME_CLKS - 1)) begin
            if (!break_req) begin
              state_q  <= IDLE;
              out_q    <= 1'b1;
              active_q <= 1'b0;
            end
          end else begin
            brk_q <= brk_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
